insn_aligner: RTL and testbench
===============================

// Module: insn_aligner
// PURPOSE
//  Parametrised parcel queue between fetch and decode; successor of the fixed 2-parcel low/high read.
//  Buffers 16-bit parcels and aligns them into up to ISSUE_WIDTH RV32/RV32C insns per cycle.
//  Carries per-parcel pc, fetch fault and interrupt tags; decoders consume the out_* slots.
// PARAMETERS
//  PARCELS_PER_FETCH  2   16-bit parcels per fetch beat (P)
//  DEPTH              8   buffer capacity in parcels; power of two, >= P+2*ISSUE_WIDTH
//  ISSUE_WIDTH        2   aligned insn slots per cycle (W)
//  VADDR_WIDTH        32  virtual address width
// PORTS
//  clk             in   1        clock
//  rst             in   1        synchronous reset, active-low (rst==0 resets)
//  fetch_valid     in   1        fetch beat present
//  fetch_ready     out  1        beat accepted when fetch_valid&&fetch_ready
//  fetch_pc        in   VADDR    pc of parcel 0; parcel i pc = fetch_pc+2*i
//  fetch_parcels   in   16*P     parcel i at [16i+15:16i]
//  fetch_mask      in   P        parcel valid; set bits contiguous, any start index
//  fetch_fault     in   1        page fault, tags every pushed parcel of the beat
//  fetch_irq_valid in   1        interrupt tag, applied to first pushed parcel only
//  fetch_irq_code  in   4        interrupt code for that parcel
//  out_valid       out  W        slot k holds an insn; bits contiguous from slot 0
//  out_pc          out  W*VADDR  slot pc
//  out_insn        out  W*32     {16'h0,p} if compressed else {hi,lo}
//  out_compressed  out  W        insn[1:0]!=2'b11
//  out_fault       out  W        fault on any consumed parcel of slot
//  out_irq_valid   out  W        interrupt on any consumed parcel of slot
//  out_irq_code    out  W*4      code from lowest tagged parcel
//  out_ready       in   1        decode takes all valid slots this cycle
//  flush           in   1        drop all buffered parcels
//  count           out  $clog2(DEPTH+1)  parcels currently buffered
// BEHAVIOUR
//  - Storage: circular array, rd_ptr/wr_ptr mod DEPTH, count register; entry {parcel,pc,fault,irq,code}.
//  - Reset (rst==0 at edge): rd_ptr=wr_ptr=count=0. Slot outputs are combinational from storage,
//    so with rst held low: out_valid=0, all slot fields 0, fetch_ready=0, count=0.
//  - fetch_ready = rst && (DEPTH-count >= P); uses registered count only, not same-cycle pops.
//  - Push: only masked parcels written, packed from wr_ptr in index order; wr_ptr/count += popcount(mask).
//  - fetch_mask==0 with fetch_valid: accepted, no state change.
//  - Alignment: slot 0 starts at rd_ptr; slot k starts after slots 0..k-1's parcels.
//  - Slot k valid iff slot k-1 valid (k>0), no earlier slot trapped, and parcels available:
//    compressed needs 1; 32-bit needs 2, OR 1 if that parcel has fault/irq (trap issued with hi=0).
//  - Slot carrying fault or irq ends the group: later slots invalid that cycle.
//  - Invalid slots drive pc/insn/flags/code = 0.
//  - Latency: parcel pushed at edge N is visible on out_* after edge N (one cycle fetch->slot).
//  - Pop: out_ready && any out_valid -> rd_ptr/count -= parcels consumed by all valid slots.
//  - Simultaneous push+pop: count_next = count + pushed - popped; pointers wrap independently.
//  - flush=1: rd_ptr=wr_ptr=count=0 next cycle; overrides same-cycle push and pop.
//  - rst low mid-operation overrides flush/push/pop; buffered parcels lost.
//  - Full: count==DEPTH -> fetch_ready=0; empty: out_valid=0.
// TESTING
//  - Push {0x0001,0x4501} mask 2'b11 pc 0x100 -> slot0 c.nop pc 0x100, slot1 0x4501 pc 0x102, both cmp.
//  - Push 0x00a00093 (addi, lo 0x0093 hi 0x00a0) pc 0x200 -> slot0 insn 0x00a00093, out_compressed=0.
//  - Push hi/lo of 32-bit split over two beats (mask 2'b10 then 2'b01) -> out_valid=0 until 2nd beat.
//  - Lone 32-bit lo parcel with fault=1 -> slot0 valid, out_fault=1, insn hi=0, slot1 invalid.
//  - Irq on parcel 0 of {c.nop,c.nop} -> only slot0 valid with irq; next cycle slot0 is 2nd c.nop.
//  - Fill to 8 with out_ready=0 -> fetch_ready=0; assert flush -> count=0, fetch_ready=1 next cycle.
//  - Drive rst=0 with count=5 -> next cycle count=0, out_valid=0, fetch_ready=0 while rst low.

Source files
------------

// File: rtl/insn_aligner.sv
// insn_aligner: parcel queue between fetch and decode.
// Buffers 16-bit parcels tagged with pc/fault/irq and aligns them into up to
// ISSUE_WIDTH RV32/RV32C instructions per cycle.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   fetch_*             fetch beat in (valid/ready, pc, parcels, mask, tags)
//   out_*               per-slot aligned insn, pc and trap tags; out_ready pops
//   flush               drop all buffered parcels
//   count               parcels currently buffered
module insn_aligner #(
  parameter int PARCELS_PER_FETCH = 2,
  parameter int DEPTH             = 8,
  parameter int ISSUE_WIDTH       = 2,
  parameter int VADDR_WIDTH       = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               fetch_valid,
  output logic                               fetch_ready,
  input  logic [VADDR_WIDTH-1:0]             fetch_pc,
  input  logic [16*PARCELS_PER_FETCH-1:0]    fetch_parcels,
  input  logic [PARCELS_PER_FETCH-1:0]       fetch_mask,
  input  logic                               fetch_fault,
  input  logic                               fetch_irq_valid,
  input  logic [3:0]                         fetch_irq_code,
  output logic [ISSUE_WIDTH-1:0]             out_valid,
  output logic [ISSUE_WIDTH*VADDR_WIDTH-1:0] out_pc,
  output logic [ISSUE_WIDTH*32-1:0]          out_insn,
  output logic [ISSUE_WIDTH-1:0]             out_compressed,
  output logic [ISSUE_WIDTH-1:0]             out_fault,
  output logic [ISSUE_WIDTH-1:0]             out_irq_valid,
  output logic [ISSUE_WIDTH*4-1:0]           out_irq_code,
  input  logic                               out_ready,
  input  logic                               flush,
  output logic [$clog2(DEPTH+1)-1:0]         count
);
  localparam int P  = PARCELS_PER_FETCH;
  localparam int W  = ISSUE_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [15:0]            parcel_q [DEPTH];
  logic [VADDR_WIDTH-1:0] pc_q     [DEPTH];
  logic                   fault_q  [DEPTH];
  logic                   irq_q    [DEPTH];
  logic [3:0]             code_q   [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q;

  logic          do_push;
  logic [CW-1:0] push_cnt;
  logic [PW-1:0] push_idx   [P];
  logic          push_en    [P];
  logic          push_first [P];
  logic [CW:0]   pos;
  logic [CW-1:0] popped;

  assign count       = count_q;
  assign fetch_ready = rst && ((CW+1)'(DEPTH) - {1'b0, count_q} >= (CW+1)'(P));
  assign do_push     = fetch_valid && fetch_ready && !flush;

  // Masked parcels are packed densely from wr_ptr; the irq tag goes only to
  // the first parcel actually written.
  always_comb begin
    push_cnt = '0;
    for (int unsigned i = 0; i < P; i++) begin
      push_en[i]    = do_push && fetch_mask[i];
      push_idx[i]   = wr_ptr + push_cnt[PW-1:0];
      push_first[i] = push_en[i] && (push_cnt == '0);
      if (push_en[i]) push_cnt = push_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < P; i++) begin
      if (push_en[i]) begin
        parcel_q[push_idx[i]] <= fetch_parcels[16*i +: 16];
        pc_q[push_idx[i]]     <= fetch_pc + VADDR_WIDTH'(2*i);
        fault_q[push_idx[i]]  <= fetch_fault;
        irq_q[push_idx[i]]    <= push_first[i] && fetch_irq_valid;
        code_q[push_idx[i]]   <= (push_first[i] && fetch_irq_valid) ? fetch_irq_code : 4'h0;
      end
    end
  end

  // Slot alignment: pos walks parcels from rd_ptr. A 32-bit insn whose low
  // parcel is trapped may issue alone (hi=0); any trapped slot, or a slot
  // lacking parcels, stops the group so valid bits stay contiguous.
  always_comb begin
    logic          stop, have1, have2, is_c, lo_trap, use_hi;
    logic [PW-1:0] i0, i1;
    logic [15:0]   lo, hi;
    out_valid      = '0;
    out_pc         = '0;
    out_insn       = '0;
    out_compressed = '0;
    out_fault      = '0;
    out_irq_valid  = '0;
    out_irq_code   = '0;
    pos            = '0;
    stop           = !rst;
    for (int unsigned k = 0; k < W; k++) begin
      i0      = rd_ptr + pos[PW-1:0];
      i1      = i0 + 1'b1;
      have1   = {1'b0, count_q} > pos;
      have2   = {1'b0, count_q} >= pos + 2'd2;
      lo      = parcel_q[i0];
      hi      = parcel_q[i1];
      is_c    = lo[1:0] != 2'b11;
      lo_trap = have1 && (fault_q[i0] || irq_q[i0]);
      use_hi  = !is_c && have2;
      if (!stop && have1 && (is_c || have2 || lo_trap)) begin
        out_valid[k]                          = 1'b1;
        out_pc[k*VADDR_WIDTH +: VADDR_WIDTH]  = pc_q[i0];
        out_insn[k*32 +: 32]                  = is_c ? {16'h0, lo} : {(use_hi ? hi : 16'h0), lo};
        out_compressed[k]                     = is_c;
        out_fault[k]                          = fault_q[i0] || (use_hi && fault_q[i1]);
        out_irq_valid[k]                      = irq_q[i0] || (use_hi && irq_q[i1]);
        out_irq_code[k*4 +: 4]                = irq_q[i0] ? code_q[i0] :
                                                (use_hi && irq_q[i1]) ? code_q[i1] : 4'h0;
        pos  = pos + (use_hi ? 2'd2 : 2'd1);
        stop = out_fault[k] || out_irq_valid[k];
      end else begin
        stop = 1'b1;
      end
    end
  end

  assign popped = (out_ready && out_valid[0]) ? pos[CW-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + push_cnt[PW-1:0];
      rd_ptr  <= rd_ptr + popped[PW-1:0];
      count_q <= count_q + push_cnt - popped;
    end
  end
endmodule

// File: tb/tb_insn_aligner.sv
// Directed self-checking bench for insn_aligner (default parameters).
module tb_insn_aligner;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_parcels;
  logic [1:0]  fetch_mask;
  logic        fetch_fault, fetch_irq_valid;
  logic [3:0]  fetch_irq_code;
  logic [1:0]  out_valid, out_compressed, out_fault, out_irq_valid;
  logic [63:0] out_pc, out_insn;
  logic [7:0]  out_irq_code;
  logic        out_ready, flush;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  insn_aligner #(
    .PARCELS_PER_FETCH(2), .DEPTH(8), .ISSUE_WIDTH(2), .VADDR_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .fetch_parcels(fetch_parcels), .fetch_mask(fetch_mask), .fetch_fault(fetch_fault),
    .fetch_irq_valid(fetch_irq_valid), .fetch_irq_code(fetch_irq_code),
    .out_valid(out_valid), .out_pc(out_pc), .out_insn(out_insn),
    .out_compressed(out_compressed), .out_fault(out_fault),
    .out_irq_valid(out_irq_valid), .out_irq_code(out_irq_code),
    .out_ready(out_ready), .flush(flush), .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1ns later, then return controls to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    fetch_valid     = 1'b0;
    fetch_mask      = 2'b00;
    fetch_fault     = 1'b0;
    fetch_irq_valid = 1'b0;
    fetch_irq_code  = 4'h0;
    out_ready       = 1'b0;
    flush           = 1'b0;
  endtask

  task automatic beat(input logic [31:0] pc, input logic [31:0] parcels, input logic [1:0] mask,
                      input logic fault, input logic irqv, input logic [3:0] code);
    fetch_valid     = 1'b1;
    fetch_pc        = pc;
    fetch_parcels   = parcels;
    fetch_mask      = mask;
    fetch_fault     = fault;
    fetch_irq_valid = irqv;
    fetch_irq_code  = code;
  endtask

  initial begin
    rst = 1'b0;
    fetch_pc = '0;
    fetch_parcels = '0;
    tick();
    tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(fetch_ready), 64'd0);
    chk("rst_insn", out_insn, 64'd0);
    rst = 1'b1;
    tick();
    chk("ready_after_rst", 64'(fetch_ready), 64'd1);

    // two compressed parcels in one beat
    beat(32'h100, 32'h4501_0001, 2'b11, 1'b0, 1'b0, 4'h0);
    tick();
    chk("c2_valid", 64'(out_valid), 64'h3);
    chk("c2_pc", out_pc, 64'h0000_0102_0000_0100);
    chk("c2_insn", out_insn, 64'h0000_4501_0000_0001);
    chk("c2_cmp", 64'(out_compressed), 64'h3);
    chk("c2_count", 64'(count), 64'd2);
    out_ready = 1'b1;
    tick();
    chk("c2_pop_count", 64'(count), 64'd0);
    chk("c2_pop_valid", 64'(out_valid), 64'd0);

    // one 32-bit insn in one beat
    beat(32'h200, 32'h00a0_0093, 2'b11, 1'b0, 1'b0, 4'h0);
    tick();
    chk("w32_valid", 64'(out_valid), 64'h1);
    chk("w32_insn", out_insn, 64'h0000_0000_00a0_0093);
    chk("w32_cmp", 64'(out_compressed), 64'h0);
    chk("w32_pc", out_pc, 64'h0000_0000_0000_0200);
    out_ready = 1'b1;
    tick();
    chk("w32_pop_count", 64'(count), 64'd0);

    // 32-bit insn split over two beats
    beat(32'h300, 32'h0093_dead, 2'b10, 1'b0, 1'b0, 4'h0);
    tick();
    chk("split1_count", 64'(count), 64'd1);
    chk("split1_valid", 64'(out_valid), 64'h0);
    beat(32'h304, 32'hbeef_00a0, 2'b01, 1'b0, 1'b0, 4'h0);
    tick();
    chk("split2_valid", 64'(out_valid), 64'h1);
    chk("split2_insn", out_insn, 64'h0000_0000_00a0_0093);
    chk("split2_pc", out_pc, 64'h0000_0000_0000_0302);
    out_ready = 1'b1;
    tick();

    // lone faulting low half of a 32-bit insn
    beat(32'h400, 32'h0000_0093, 2'b01, 1'b1, 1'b0, 4'h0);
    tick();
    chk("fault_valid", 64'(out_valid), 64'h1);
    chk("fault_flag", 64'(out_fault), 64'h1);
    chk("fault_insn", out_insn, 64'h0000_0000_0000_0093);
    out_ready = 1'b1;
    tick();
    chk("fault_pop_count", 64'(count), 64'd0);

    // irq on first of two c.nop; buffer wraps here
    beat(32'h500, 32'h0001_0001, 2'b11, 1'b0, 1'b1, 4'h5);
    tick();
    chk("irq_valid", 64'(out_valid), 64'h1);
    chk("irq_flag", 64'(out_irq_valid), 64'h1);
    chk("irq_code", 64'(out_irq_code), 64'h05);
    out_ready = 1'b1;
    tick();
    chk("irq2_count", 64'(count), 64'd1);
    chk("irq2_valid", 64'(out_valid), 64'h1);
    chk("irq2_pc", out_pc, 64'h0000_0000_0000_0502);
    chk("irq2_flag", 64'(out_irq_valid), 64'h0);
    out_ready = 1'b1;
    tick();

    // fill to full then flush
    for (int i = 0; i < 4; i++) begin
      beat(32'h700 + 32'(4*i), 32'h0001_0001, 2'b11, 1'b0, 1'b0, 4'h0);
      tick();
    end
    chk("full_count", 64'(count), 64'd8);
    chk("full_ready", 64'(fetch_ready), 64'd0);
    chk("full_valid", 64'(out_valid), 64'h3);
    flush = 1'b1;
    tick();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_ready", 64'(fetch_ready), 64'd1);
    chk("flush_valid", 64'(out_valid), 64'h0);

    // simultaneous push and pop
    beat(32'h600, 32'h0001_0001, 2'b11, 1'b0, 1'b0, 4'h0);
    tick();
    beat(32'h604, 32'h4501_4501, 2'b11, 1'b0, 1'b0, 4'h0);
    out_ready = 1'b1;
    tick();
    chk("pp_count", 64'(count), 64'd2);
    chk("pp_pc0", 64'(out_pc[31:0]), 64'h604);
    chk("pp_insn0", 64'(out_insn[31:0]), 64'h4501);

    // empty mask is accepted without effect
    beat(32'h800, 32'h0001_0001, 2'b00, 1'b0, 1'b0, 4'h0);
    tick();
    chk("mask0_count", 64'(count), 64'd2);

    // reset mid-operation with count=5
    beat(32'h900, 32'h0001_0001, 2'b11, 1'b0, 1'b0, 4'h0);
    tick();
    beat(32'h904, 32'h0001_0001, 2'b01, 1'b0, 1'b0, 4'h0);
    tick();
    chk("pre_rst_count", 64'(count), 64'd5);
    rst = 1'b0;
    tick();
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_ready", 64'(fetch_ready), 64'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_ready", 64'(fetch_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
